// File: rtl/sa_ram_rwsp_param.sv
// One-write/one-read-port RAM with two-stage read, zero-fill after reset, read-valid flag and optional bypass.
// Define SA_RAM_PARITY_EN to store an even-parity bit per word and flag mismatches on par_err.
module sa_ram_rwsp_param #(
  parameter int DW     = 14,
  parameter int AW     = 4,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          re,
  input  logic          ore,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [DW-1:0] di,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic          init_busy,
  output logic          par_err
);

  localparam int DEPTH = 1 << AW;
`ifdef SA_RAM_PARITY_EN
  localparam int WW = DW + 1;
`else
  localparam int WW = DW;
`endif
  localparam logic [AW:0] CLR_LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW:0]   r_clr_addr;
  logic [AW-1:0] r_ra_d;
  logic          r_ra_vld;
  logic [DW-1:0] r_dout;
  logic          r_dout_vld;
  logic [WW-1:0] r_mem [0:DEPTH-1];

  logic          w_ready;
  logic          w_clr_last;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_wa;
  logic [WW-1:0] w_mem_wd;
  logic [WW-1:0] w_di_word;
  logic [WW-1:0] w_rd_word;
  logic          w_bypass;
  logic          w_unused_pwr;

  assign w_unused_pwr = ^pwrbus_ram_pd;
  assign w_ready      = (r_state == READY);
  assign w_clr_last   = (r_clr_addr == CLR_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (w_clr_last) w_state_next = READY;
      READY:   w_state_next = READY;
      default: w_state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == CLEAR) r_clr_addr <= r_clr_addr + {{AW{1'b0}}, 1'b1};
    end
  end

`ifdef SA_RAM_PARITY_EN
  assign w_di_word = {^di, di};
`else
  assign w_di_word = di;
`endif

  // The zero-fill sweep owns the single write port until READY.
  assign w_mem_we = (r_state == CLEAR) | (w_ready & we);
  assign w_mem_wa = w_ready ? wa : r_clr_addr[AW-1:0];
  assign w_mem_wd = w_ready ? w_di_word : '0;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
  end

  assign w_rd_word = r_mem[r_ra_d];
  assign w_bypass  = (BYPASS != 0) && we && ore && (wa == r_ra_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra_d     <= '0;
      r_ra_vld   <= 1'b0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else if (w_ready) begin
      if (re) begin
        r_ra_d   <= ra;
        r_ra_vld <= 1'b1;
      end
      if (ore) begin
        r_dout     <= w_bypass ? di : w_rd_word[DW-1:0];
        r_dout_vld <= r_ra_vld;
      end
    end
  end

`ifdef SA_RAM_PARITY_EN
  logic r_par_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_ready && ore) begin
      // Forwarded write data carries fresh parity, so it can never mismatch.
      r_par_err <= w_bypass ? 1'b0 : (r_ra_vld & ((^w_rd_word[DW-1:0]) != w_rd_word[DW]));
    end
  end
  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

  assign dout      = r_dout;
  assign dout_vld  = r_dout_vld;
  assign init_busy = (r_state == CLEAR);

endmodule

// File: tb/tb_sa_ram_rwsp_param.sv
// Directed scoreboard bench for sa_ram_rwsp_param; a BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_sa_ram_rwsp_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ra = '0, wa = '0;
  logic        re = 1'b0, ore = 1'b0, we = 1'b0;
  logic [13:0] di = '0;
  logic [31:0] pwrbus_ram_pd = 32'h5A5A_0F0F;

  logic [13:0] dout, dout0;
  logic        dout_vld, dout_vld0, init_busy, init_busy0, par_err, par_err0;

  sa_ram_rwsp_param #(.DW(14), .AW(4), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout), .dout_vld(dout_vld),
    .wa(wa), .we(we), .di(di), .pwrbus_ram_pd(pwrbus_ram_pd), .init_busy(init_busy), .par_err(par_err)
  );

  sa_ram_rwsp_param #(.DW(14), .AW(4), .BYPASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout0), .dout_vld(dout_vld0),
    .wa(wa), .we(we), .di(di), .pwrbus_ram_pd(pwrbus_ram_pd), .init_busy(init_busy0), .par_err(par_err0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] dout;
    logic [13:0] dout0;
    logic        vld;
    logic        par;
    logic        par0;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  logic [13:0] mdl [16];
  logic        m_bad [16];
  logic [3:0]  m_ra_d;
  logic        m_ra_vld, m_vld, m_par, m_par0, m_busy;
  logic [13:0] m_dout, m_dout0;
  int          m_clr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      mdl[i]   = '0;
      m_bad[i] = 1'b0;
    end
    m_ra_d = '0; m_ra_vld = 1'b0; m_vld = 1'b0; m_par = 1'b0; m_par0 = 1'b0;
    m_dout = '0; m_dout0 = '0; m_busy = 1'b1; m_clr = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_dout"}, 32'(dout), 32'h0);
    check({tag, "_dout0"}, 32'(dout0), 32'h0);
    check({tag, "_vld"}, 32'(dout_vld), 32'h0);
    check({tag, "_vld0"}, 32'(dout_vld0), 32'h0);
    check({tag, "_busy"}, 32'(init_busy), 32'h1);
    check({tag, "_busy0"}, 32'(init_busy0), 32'h1);
    check({tag, "_par"}, 32'(par_err), 32'h0);
  endtask

  // One clock: drive on the falling edge, predict, then compare 1 unit after the rising edge.
  task automatic step(input string tag, input logic s_we, input logic [3:0] s_wa, input logic [13:0] s_di,
                      input logic s_re, input logic [3:0] s_ra, input logic s_ore);
    exp_t e;
    logic byp;
    @(negedge clk);
    we = s_we; wa = s_wa; di = s_di; re = s_re; ra = s_ra; ore = s_ore;
    if (!m_busy) begin
      if (s_ore) begin
        byp     = s_we && (s_wa == m_ra_d);
        m_dout  = byp ? s_di : mdl[m_ra_d];
        m_dout0 = mdl[m_ra_d];
        m_vld   = m_ra_vld;
        m_par   = byp ? 1'b0 : (m_ra_vld & m_bad[m_ra_d]);
        m_par0  = m_ra_vld & m_bad[m_ra_d];
      end
      if (s_we) begin
        mdl[s_wa]   = s_di;
        m_bad[s_wa] = 1'b0;
      end
      if (s_re) begin
        m_ra_d   = s_ra;
        m_ra_vld = 1'b1;
      end
    end else begin
      m_clr++;
      if (m_clr == 16) m_busy = 1'b0;
    end
    e.dout = m_dout; e.dout0 = m_dout0; e.vld = m_vld;
    e.par = m_par; e.par0 = m_par0; e.busy = m_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, "_dout"}, 32'(dout), 32'(e.dout));
    check({tag, "_dout0"}, 32'(dout0), 32'(e.dout0));
    check({tag, "_vld"}, 32'(dout_vld), 32'(e.vld));
    check({tag, "_vld0"}, 32'(dout_vld0), 32'(e.vld));
    check({tag, "_busy"}, 32'(init_busy), 32'(e.busy));
    check({tag, "_busy0"}, 32'(init_busy0), 32'(e.busy));
    check({tag, "_par"}, 32'(par_err), 32'(e.par));
    check({tag, "_par0"}, 32'(par_err0), 32'(e.par0));
    $display("step %-10s we=%0d wa=%0d di=%h re=%0d ra=%0d ore=%0d -> dout=%h dout0=%h vld=%0d busy=%0d par=%0d",
             tag, s_we, s_wa, s_di, s_re, s_ra, s_ore, dout, dout0, dout_vld, init_busy, par_err);
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");
    #1 rst = 1'b0;

    // Port traffic during the zero-fill must be dropped.
    for (int i = 0; i < 8; i++) step("clr_drop", 1'b1, 4'd5, 14'h3FFF, 1'b1, 4'd5, 1'b1);

    // Asynchronous reset mid-clear: outputs return at once, sweep restarts.
    #1 rst = 1'b1;
    #1 check_reset("rst_mid");
    #1 rst = 1'b0;
    m_reset();
    for (int i = 0; i < 16; i++) step("clear", i[0], 4'd5, 14'h1555, 1'b1, 4'd5, i[1]);

    // Sweep all addresses: first capture precedes any accepted re.
    for (int i = 0; i < 16; i++) step("rd_zero", 1'b0, 4'd0, 14'h0, 1'b1, 4'(i), 1'b1);
    step("rd_zero", 1'b0, 4'd0, 14'h0, 1'b0, 4'd0, 1'b1);

    step("wr3", 1'b1, 4'd3, 14'h2A5B, 1'b0, 4'd0, 1'b0);
    step("re3", 1'b0, 4'd0, 14'h0, 1'b1, 4'd3, 1'b0);
    step("ore3", 1'b0, 4'd0, 14'h0, 1'b0, 4'd0, 1'b1);

    // Collision: BYPASS=1 forwards di, BYPASS=0 returns the old word.
    step("wr7", 1'b1, 4'd7, 14'h0BEE, 1'b0, 4'd0, 1'b0);
    step("re7", 1'b0, 4'd0, 14'h0, 1'b1, 4'd7, 1'b0);
    step("byp7", 1'b1, 4'd7, 14'h1234, 1'b0, 4'd0, 1'b1);
    step("after7", 1'b0, 4'd0, 14'h0, 1'b0, 4'd0, 1'b1);

    // Same-edge write and re of one address, then re+ore overlap.
    step("wre9", 1'b1, 4'd9, 14'h3C3C, 1'b1, 4'd9, 1'b0);
    step("ore9", 1'b0, 4'd0, 14'h0, 1'b0, 4'd0, 1'b1);
    step("re3b", 1'b0, 4'd0, 14'h0, 1'b1, 4'd3, 1'b0);
    step("re9ore", 1'b0, 4'd0, 14'h0, 1'b1, 4'd9, 1'b1);
    step("ore9b", 1'b0, 4'd0, 14'h0, 1'b0, 4'd0, 1'b1);

    // Output register holds while ore is low.
    for (int i = 0; i < 5; i++) step("hold", 1'b1, 4'(i), 14'(i * 7 + 1), 1'b1, 4'(i), 1'b0);

    for (int i = 0; i < 40; i++)
      step("rand", 1'($urandom_range(1)), 4'($urandom_range(15)), 14'($urandom_range(16383)),
           1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)));

`ifdef SA_RAM_PARITY_EN
    step("par_wr2", 1'b1, 4'd2, 14'h0001, 1'b0, 4'd0, 1'b0);
    u_dut.r_mem[2][4]  = ~u_dut.r_mem[2][4];
    u_dut0.r_mem[2][4] = ~u_dut0.r_mem[2][4];
    mdl[2]   = mdl[2] ^ 14'h0010;
    m_bad[2] = 1'b1;
    step("par_re2", 1'b0, 4'd0, 14'h0, 1'b1, 4'd2, 1'b0);
    step("par_ore2", 1'b0, 4'd0, 14'h0, 1'b0, 4'd0, 1'b1);
    step("par_re1", 1'b0, 4'd0, 14'h0, 1'b1, 4'd1, 1'b0);
    step("par_ore1", 1'b0, 4'd0, 14'h0, 1'b0, 4'd0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
